// File: rtl/tile_pixel_shifter_pkg.sv
// tile_pixel_shifter_pkg: shared defaults, per-clock operation code and counter width helper
package tile_pixel_shifter_pkg;
    localparam int PLANE_W_DEF    = 8;
    localparam int NUM_PLANES_DEF = 3;
    localparam int ATTR_W_DEF     = 6;
    typedef enum logic [1:0] {OP_HOLD, OP_CLR, OP_LOAD, OP_SHIFT} op_e;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/tile_pixel_shifter_if.sv
// tile_pixel_shifter_if: pixel shifter control, plane data and pixel output bundle
interface tile_pixel_shifter_if
    import tile_pixel_shifter_pkg::*;
#(
    parameter int PLANE_W    = PLANE_W_DEF,
    parameter int NUM_PLANES = NUM_PLANES_DEF,
    parameter int ATTR_W     = ATTR_W_DEF
);
    logic                          Cen;
    logic                          Clr_n;
    logic                          Inh;
    logic                          Load_n;
    logic                          Flip;
    logic [NUM_PLANES*PLANE_W-1:0] Planes;
    logic [ATTR_W-1:0]             Attr_in;
    logic [NUM_PLANES-1:0]         Pix;
    logic [ATTR_W-1:0]             Attr_out;
    logic                          Empty;
    modport master (output Cen, Clr_n, Inh, Load_n, Flip, Planes, Attr_in, input Pix, Attr_out, Empty);
    modport slave  (input Cen, Clr_n, Inh, Load_n, Flip, Planes, Attr_in, output Pix, Attr_out, Empty);
endinterface

// File: rtl/tile_pixel_shifter_ttl_74166_sync.sv
// ttl_74166_sync: one PISO bitplane register driven by a pre-qualified operation code
module ttl_74166_sync
    import tile_pixel_shifter_pkg::*;
#(
    parameter int W = PLANE_W_DEF
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  op_e          op_i,
    input  logic         flip_i,
    input  logic [W-1:0] d_i,
    output logic         q_o
);
    logic [W-1:0] sr_q = '0;
    logic [W-1:0] sr_d;
    logic [W-1:0] rev;
    always_comb begin
        for (int i = 0; i < W; i++) rev[i] = d_i[W-1-i];
        sr_d = op_i == OP_CLR   ? '0 :
               op_i == OP_LOAD  ? (flip_i ? rev : d_i) :
               op_i == OP_SHIFT ? W'({sr_q, 1'b0}) : sr_q;
    end
    always_ff @(posedge Clk) begin
        if (!Reset_n) sr_q <= '0;
        else          sr_q <= sr_d;
    end
    assign q_o = sr_q[W-1];
endmodule

// File: rtl/tile_pixel_shifter.sv
// tile_pixel_shifter: multi-plane tile pixel serializer with Cen edge detect, pixel counter and attribute latch
module tile_pixel_shifter
    import tile_pixel_shifter_pkg::*;
#(
    parameter int PLANE_W    = PLANE_W_DEF,
    parameter int NUM_PLANES = NUM_PLANES_DEF,
    parameter int ATTR_W     = ATTR_W_DEF
) (
    input logic                 Clk,
    input logic                 Reset_n,
    tile_pixel_shifter_if.slave bus
);
    localparam int CW = cnt_w(PLANE_W);
    // last_cen resets high so a Cen already high at reset release is not an edge
    logic              last_cen_q = 1'b1;
    logic [CW-1:0]     cnt_q = '0;
    logic [CW-1:0]     cnt_d;
    logic [ATTR_W-1:0] attr_q = '0;
    logic [ATTR_W-1:0] attr_d;
    logic              cen_edge;
    op_e               op;
    logic [NUM_PLANES-1:0] pix;
    always_comb begin
        cen_edge = bus.Cen & ~last_cen_q;
        op       = !bus.Clr_n            ? OP_CLR  :
                   !cen_edge || bus.Inh  ? OP_HOLD :
                   !bus.Load_n           ? OP_LOAD : OP_SHIFT;
        cnt_d    = op == OP_CLR                  ? '0 :
                   op == OP_LOAD                 ? CW'(PLANE_W) :
                   op == OP_SHIFT && cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
        attr_d   = op == OP_CLR  ? '0 :
                   op == OP_LOAD ? bus.Attr_in : attr_q;
    end
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            last_cen_q <= 1'b1;
            cnt_q      <= '0;
            attr_q     <= '0;
        end else begin
            last_cen_q <= bus.Cen;
            cnt_q      <= cnt_d;
            attr_q     <= attr_d;
        end
    end
    for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
        ttl_74166_sync #(.W(PLANE_W)) u_plane (
            .Clk    (Clk),
            .Reset_n(Reset_n),
            .op_i   (op),
            .flip_i (bus.Flip),
            .d_i    (bus.Planes[p*PLANE_W +: PLANE_W]),
            .q_o    (pix[p])
        );
    end
    assign bus.Pix      = pix;
    assign bus.Attr_out = attr_q;
    assign bus.Empty    = cnt_q == '0;
endmodule
